// File: rtl/mem_port_arbiter_if.sv
// Bundle of the CPU port (a_*), DMA port (b_*) and single-port RAM signals
// seen by mem_port_arbiter; slave is the arbiter's view, master the environment's.
interface mem_port_arbiter_if #(
    parameter int AW = 14,
    parameter int DW = 32
);
    logic          a_req;
    logic          a_we;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_wdata;
    logic [DW-1:0] a_rdata;
    logic          a_ack;
    logic          a_stall;

    logic          b_req;
    logic          b_we;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_wdata;
    logic [DW-1:0] b_rdata;
    logic          b_ack;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    logic          busy;

    modport slave (
        input  a_req, a_we, a_addr, a_wdata,
        output a_rdata, a_ack, a_stall,
        input  b_req, b_we, b_addr, b_wdata,
        output b_rdata, b_ack,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata,
        output busy
    );

    modport master (
        output a_req, a_we, a_addr, a_wdata,
        input  a_rdata, a_ack, a_stall,
        output b_req, b_we, b_addr, b_wdata,
        input  b_rdata, b_ack,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata,
        input  busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter in front of the single-port data RAM: CPU (A) has fixed
// priority, DMA (B) is forced through after MAX_STARVE contested CPU wins.
module mem_port_arbiter #(
    parameter int AW         = 14,
    parameter int DW         = 32,
    parameter int RD_LAT     = 1,
    parameter int MAX_STARVE = 4
) (
    input logic               clk,
    input logic               rst,
    mem_port_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } state_t;

    typedef enum logic {
        OWN_A,
        OWN_B
    } owner_t;

    state_t        state;
    state_t        state_next;
    owner_t        owner;

    logic          we_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [1:0]    wait_cnt;
    logic [3:0]    starve_cnt;
    logic [DW-1:0] a_rdata_q;
    logic [DW-1:0] b_rdata_q;

    logic          starved;
    logic          grant_a;
    logic          grant_b;
    logic          done;
    logic          read_done;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          a_ack;
    logic          b_ack;

    assign starved = (starve_cnt == 4'(MAX_STARVE));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Grants are decided only in IDLE; ISSUE is the single RAM strobe cycle.
    always_comb begin
        state_next = state;
        grant_a    = 1'b0;
        grant_b    = 1'b0;
        done       = 1'b0;
        read_done  = 1'b0;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        case (state)
            IDLE: begin
                grant_b = bus.b_req & (~bus.a_req | starved);
                grant_a = bus.a_req & ~grant_b;
                if (grant_a | grant_b) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                mem_en    = 1'b1;
                mem_we    = we_q;
                mem_addr  = addr_q;
                mem_wdata = wdata_q;
                if (we_q) begin
                    done       = 1'b1;
                    state_next = IDLE;
                end else begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (wait_cnt == 2'd0) begin
                    done       = 1'b1;
                    read_done  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign a_ack = done & (owner == OWN_A);
    assign b_ack = done & (owner == OWN_B);

    // The granted request is latched so the RAM side does not depend on the
    // requester holding its address/data beyond the arbitration edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner      <= OWN_A;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            starve_cnt <= 4'd0;
        end else if (grant_a | grant_b) begin
            owner   <= grant_b ? OWN_B : OWN_A;
            we_q    <= grant_b ? bus.b_we : bus.a_we;
            addr_q  <= grant_b ? bus.b_addr : bus.a_addr;
            wdata_q <= grant_b ? bus.b_wdata : bus.a_wdata;
            if (grant_a & bus.b_req) begin
                starve_cnt <= starved ? starve_cnt : starve_cnt + 4'd1;
            end else begin
                starve_cnt <= 4'd0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt <= 2'd0;
        end else if (state == ISSUE) begin
            wait_cnt <= 2'(RD_LAT - 1);
        end else if ((state == WAIT) && (wait_cnt != 2'd0)) begin
            wait_cnt <= wait_cnt - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_rdata_q <= '0;
            b_rdata_q <= '0;
        end else if (read_done) begin
            if (owner == OWN_A) begin
                a_rdata_q <= bus.mem_rdata;
            end else begin
                b_rdata_q <= bus.mem_rdata;
            end
        end
    end

    // Read data is forwarded in the ack cycle itself, then held from the register.
    assign bus.a_rdata   = (read_done && (owner == OWN_A)) ? bus.mem_rdata : a_rdata_q;
    assign bus.b_rdata   = (read_done && (owner == OWN_B)) ? bus.mem_rdata : b_rdata_q;
    assign bus.a_ack     = a_ack;
    assign bus.b_ack     = b_ack;
    assign bus.a_stall   = bus.a_req & ~a_ack;
    assign bus.mem_en    = mem_en;
    assign bus.mem_we    = mem_we;
    assign bus.mem_addr  = mem_addr;
    assign bus.mem_wdata = mem_wdata;
    assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a per-cycle vector table on an RD_LAT=1
// instance plus hand sequences for starvation, mid-read reset and RD_LAT=3.
module tb_mem_port_arbiter;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    mem_port_arbiter_if #(.AW(14), .DW(32)) bus1 ();
    mem_port_arbiter_if #(.AW(14), .DW(32)) bus3 ();

    mem_port_arbiter #(.AW(14), .DW(32), .RD_LAT(1), .MAX_STARVE(4)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    mem_port_arbiter #(.AW(14), .DW(32), .RD_LAT(3), .MAX_STARVE(4)) u_dut3 (
        .clk (clk),
        .rst (rst),
        .bus (bus3)
    );

    typedef struct packed {
        logic        a_req;
        logic        a_we;
        logic [13:0] a_addr;
        logic [31:0] a_wdata;
        logic        b_req;
        logic        b_we;
        logic [13:0] b_addr;
        logic [31:0] b_wdata;
        logic [31:0] mem_rdata;
        logic        x_a_ack;
        logic        x_a_stall;
        logic [31:0] x_a_rdata;
        logic        x_b_ack;
        logic [31:0] x_b_rdata;
        logic        x_mem_en;
        logic        x_mem_we;
        logic [13:0] x_mem_addr;
        logic [31:0] x_mem_wdata;
        logic        x_busy;
    } vec_t;

    vec_t vecs [16];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got no finish, required finish before 100000 ns");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkBit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %b, required %b", name, act, exp);
        end
    endtask

    task automatic checkWord(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        bus1.a_req     = v.a_req;
        bus1.a_we      = v.a_we;
        bus1.a_addr    = v.a_addr;
        bus1.a_wdata   = v.a_wdata;
        bus1.b_req     = v.b_req;
        bus1.b_we      = v.b_we;
        bus1.b_addr    = v.b_addr;
        bus1.b_wdata   = v.b_wdata;
        bus1.mem_rdata = v.mem_rdata;
    endtask

    task automatic checkOutput(input int idx, input vec_t v);
        checkBit ($sformatf("vec%0d a_ack", idx),     bus1.a_ack,     v.x_a_ack);
        checkBit ($sformatf("vec%0d a_stall", idx),   bus1.a_stall,   v.x_a_stall);
        checkWord($sformatf("vec%0d a_rdata", idx),   bus1.a_rdata,   v.x_a_rdata);
        checkBit ($sformatf("vec%0d b_ack", idx),     bus1.b_ack,     v.x_b_ack);
        checkWord($sformatf("vec%0d b_rdata", idx),   bus1.b_rdata,   v.x_b_rdata);
        checkBit ($sformatf("vec%0d mem_en", idx),    bus1.mem_en,    v.x_mem_en);
        checkBit ($sformatf("vec%0d mem_we", idx),    bus1.mem_we,    v.x_mem_we);
        checkWord($sformatf("vec%0d mem_addr", idx),  32'(bus1.mem_addr), 32'(v.x_mem_addr));
        checkWord($sformatf("vec%0d mem_wdata", idx), bus1.mem_wdata, v.x_mem_wdata);
        checkBit ($sformatf("vec%0d busy", idx),      bus1.busy,      v.x_busy);
    endtask

    initial begin
        int   starve;
        logic own_b;
        logic exp_a;
        logic exp_b;

        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b0;
        applyStimulus('0);
        bus3.a_req = 1'b0; bus3.a_we = 1'b0; bus3.a_addr = '0; bus3.a_wdata = '0;
        bus3.b_req = 1'b0; bus3.b_we = 1'b0; bus3.b_addr = '0; bus3.b_wdata = '0;
        bus3.mem_rdata = '0;

        //            a_req a_we  a_addr    a_wdata       b_req b_we  b_addr    b_wdata       mem_rdata     a_ack a_stl a_rdata       b_ack b_rdata       mem_en mem_we mem_addr wdata        busy
        vecs[0]  = '{1'b1, 1'b0, 14'h010, 32'h0,        1'b0, 1'b0, 14'h0,   32'h0,        32'h0,        1'b0, 1'b1, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 14'h0,   32'h0,        1'b0};
        vecs[1]  = '{1'b1, 1'b0, 14'h010, 32'h0,        1'b0, 1'b0, 14'h0,   32'h0,        32'h0,        1'b0, 1'b1, 32'h0,        1'b0, 32'h0,        1'b1, 1'b0, 14'h010, 32'h0,        1'b1};
        vecs[2]  = '{1'b1, 1'b0, 14'h010, 32'h0,        1'b0, 1'b0, 14'h0,   32'h0,        32'hDEADBEEF, 1'b1, 1'b0, 32'hDEADBEEF, 1'b0, 32'h0,        1'b0, 1'b0, 14'h0,   32'h0,        1'b1};
        vecs[3]  = '{1'b0, 1'b0, 14'h0,   32'h0,        1'b0, 1'b0, 14'h0,   32'h0,        32'h0BADF00D, 1'b0, 1'b0, 32'hDEADBEEF, 1'b0, 32'h0,        1'b0, 1'b0, 14'h0,   32'h0,        1'b0};
        vecs[4]  = '{1'b1, 1'b1, 14'h3FF, 32'h12345678, 1'b0, 1'b0, 14'h0,   32'h0,        32'h0,        1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0,        1'b0, 1'b0, 14'h0,   32'h0,        1'b0};
        vecs[5]  = '{1'b1, 1'b1, 14'h3FF, 32'h12345678, 1'b0, 1'b0, 14'h0,   32'h0,        32'h0,        1'b1, 1'b0, 32'hDEADBEEF, 1'b0, 32'h0,        1'b1, 1'b1, 14'h3FF, 32'h12345678, 1'b1};
        vecs[6]  = '{1'b0, 1'b0, 14'h0,   32'h0,        1'b0, 1'b0, 14'h0,   32'h0,        32'h0,        1'b0, 1'b0, 32'hDEADBEEF, 1'b0, 32'h0,        1'b0, 1'b0, 14'h0,   32'h0,        1'b0};
        vecs[7]  = '{1'b1, 1'b1, 14'h020, 32'hA5A5A5A5, 1'b1, 1'b1, 14'h030, 32'h5A5A5A5A, 32'h0,        1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0,        1'b0, 1'b0, 14'h0,   32'h0,        1'b0};
        vecs[8]  = '{1'b1, 1'b1, 14'h020, 32'hA5A5A5A5, 1'b1, 1'b1, 14'h030, 32'h5A5A5A5A, 32'h0,        1'b1, 1'b0, 32'hDEADBEEF, 1'b0, 32'h0,        1'b1, 1'b1, 14'h020, 32'hA5A5A5A5, 1'b1};
        vecs[9]  = '{1'b0, 1'b0, 14'h0,   32'h0,        1'b1, 1'b1, 14'h030, 32'h5A5A5A5A, 32'h0,        1'b0, 1'b0, 32'hDEADBEEF, 1'b0, 32'h0,        1'b0, 1'b0, 14'h0,   32'h0,        1'b0};
        vecs[10] = '{1'b0, 1'b0, 14'h0,   32'h0,        1'b1, 1'b1, 14'h030, 32'h5A5A5A5A, 32'h0,        1'b0, 1'b0, 32'hDEADBEEF, 1'b1, 32'h0,        1'b1, 1'b1, 14'h030, 32'h5A5A5A5A, 1'b1};
        vecs[11] = '{1'b0, 1'b0, 14'h0,   32'h0,        1'b0, 1'b0, 14'h0,   32'h0,        32'h0,        1'b0, 1'b0, 32'hDEADBEEF, 1'b0, 32'h0,        1'b0, 1'b0, 14'h0,   32'h0,        1'b0};
        vecs[12] = '{1'b0, 1'b0, 14'h0,   32'h0,        1'b1, 1'b0, 14'h055, 32'h0,        32'h0,        1'b0, 1'b0, 32'hDEADBEEF, 1'b0, 32'h0,        1'b0, 1'b0, 14'h0,   32'h0,        1'b0};
        vecs[13] = '{1'b0, 1'b0, 14'h0,   32'h0,        1'b1, 1'b0, 14'h055, 32'h0,        32'h0,        1'b0, 1'b0, 32'hDEADBEEF, 1'b0, 32'h0,        1'b1, 1'b0, 14'h055, 32'h0,        1'b1};
        vecs[14] = '{1'b0, 1'b0, 14'h0,   32'h0,        1'b1, 1'b0, 14'h055, 32'h0,        32'hCAFEF00D, 1'b0, 1'b0, 32'hDEADBEEF, 1'b1, 32'hCAFEF00D, 1'b0, 1'b0, 14'h0,   32'h0,        1'b1};
        vecs[15] = '{1'b0, 1'b0, 14'h0,   32'h0,        1'b0, 1'b0, 14'h0,   32'h0,        32'h0,        1'b0, 1'b0, 32'hDEADBEEF, 1'b0, 32'hCAFEF00D, 1'b0, 1'b0, 14'h0,   32'h0,        1'b0};

        $display("[TB] reset state");
        repeat (2) @(negedge clk);
        checkBit ("rst busy1",   bus1.busy,   1'b0);
        checkBit ("rst mem_en1", bus1.mem_en, 1'b0);
        checkBit ("rst a_ack1",  bus1.a_ack,  1'b0);
        checkBit ("rst b_ack1",  bus1.b_ack,  1'b0);
        checkWord("rst a_rdata1", bus1.a_rdata, 32'h0);
        checkBit ("rst busy3",   bus3.busy,   1'b0);
        bus1.a_req = 1'b1;
        #1;
        checkBit ("rst a_stall follows a_req", bus1.a_stall, 1'b1);
        checkBit ("rst mem_en with a_req", bus1.mem_en, 1'b0);
        bus1.a_req = 1'b0;
        #1;
        checkBit ("rst a_stall low", bus1.a_stall, 1'b0);
        @(posedge clk);
        #1 rst = 1'b1;

        $display("[TB] vector table");
        for (int i = 0; i < 16; i++) begin
            @(posedge clk);
            #1 applyStimulus(vecs[i]);
            @(negedge clk);
            checkOutput(i, vecs[i]);
        end

        $display("[TB] starvation sequence");
        starve = 0;
        own_b  = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            bus1.a_req = 1'b1; bus1.a_we = 1'b1; bus1.a_addr = 14'h100; bus1.a_wdata = 32'h0000AAAA;
            bus1.b_req = 1'b1; bus1.b_we = 1'b1; bus1.b_addr = 14'h200; bus1.b_wdata = 32'h0000BBBB;
            bus1.mem_rdata = 32'h0;
            if ((k % 2) == 0) begin
                own_b = (starve == 4);
                starve = own_b ? 0 : ((starve == 4) ? 4 : starve + 1);
                exp_a = 1'b0;
                exp_b = 1'b0;
            end else begin
                exp_a = ~own_b;
                exp_b = own_b;
            end
            @(negedge clk);
            checkBit ($sformatf("starve%0d a_ack", k),   bus1.a_ack,   exp_a);
            checkBit ($sformatf("starve%0d b_ack", k),   bus1.b_ack,   exp_b);
            checkBit ($sformatf("starve%0d a_stall", k), bus1.a_stall, ~exp_a);
            checkBit ($sformatf("starve%0d mem_en", k),  bus1.mem_en,  1'(k % 2));
            if ((k % 2) == 1) begin
                checkWord($sformatf("starve%0d mem_addr", k), 32'(bus1.mem_addr), own_b ? 32'h200 : 32'h100);
            end
        end
        @(posedge clk);
        #1 applyStimulus('0);
        @(negedge clk);
        checkBit("post-starve busy", bus1.busy, 1'b0);

        $display("[TB] reset during read wait");
        @(posedge clk);
        #1;
        bus1.a_req = 1'b1; bus1.a_we = 1'b0; bus1.a_addr = 14'h077;
        bus1.mem_rdata = 32'h11111111;
        @(negedge clk);
        checkBit("mid R0 busy", bus1.busy, 1'b0);
        @(negedge clk);
        checkBit ("mid R1 mem_en", bus1.mem_en, 1'b1);
        checkWord("mid R1 mem_addr", 32'(bus1.mem_addr), 32'h077);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkBit ("mid R2 mem_en", bus1.mem_en, 1'b0);
        checkBit ("mid R2 busy",   bus1.busy,   1'b0);
        checkBit ("mid R2 a_ack",  bus1.a_ack,  1'b0);
        checkBit ("mid R2 a_stall", bus1.a_stall, 1'b1);
        checkWord("mid R2 a_rdata", bus1.a_rdata, 32'h0);
        checkWord("mid R2 b_rdata", bus1.b_rdata, 32'h0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        checkBit("mid R3 busy", bus1.busy, 1'b0);
        checkBit("mid R3 mem_en", bus1.mem_en, 1'b0);
        @(negedge clk);
        checkBit ("mid R4 mem_en", bus1.mem_en, 1'b1);
        checkWord("mid R4 mem_addr", 32'(bus1.mem_addr), 32'h077);
        checkBit ("mid R4 a_ack", bus1.a_ack, 1'b0);
        @(posedge clk);
        #1 bus1.mem_rdata = 32'h600DF00D;
        @(negedge clk);
        checkBit ("mid R5 a_ack", bus1.a_ack, 1'b1);
        checkWord("mid R5 a_rdata", bus1.a_rdata, 32'h600DF00D);
        @(posedge clk);
        #1 applyStimulus('0);
        @(negedge clk);
        checkWord("mid R6 a_rdata held", bus1.a_rdata, 32'h600DF00D);
        checkBit ("mid R6 busy", bus1.busy, 1'b0);

        $display("[TB] port B read, RD_LAT=3");
        @(posedge clk);
        #1;
        bus3.b_req = 1'b1; bus3.b_we = 1'b0; bus3.b_addr = 14'h1A0;
        bus3.mem_rdata = 32'hFFFFFFFF;
        for (int c = 0; c < 5; c++) begin
            if (c == 4) begin
                bus3.mem_rdata = 32'h13579BDF;
            end
            @(negedge clk);
            checkBit ($sformatf("lat3 c%0d mem_en", c),  bus3.mem_en,  1'(c == 1));
            checkBit ($sformatf("lat3 c%0d b_ack", c),   bus3.b_ack,   1'(c == 4));
            checkBit ($sformatf("lat3 c%0d busy", c),    bus3.busy,    1'(c != 0));
            checkBit ($sformatf("lat3 c%0d a_stall", c), bus3.a_stall, 1'b0);
            checkWord($sformatf("lat3 c%0d b_rdata", c), bus3.b_rdata, (c == 4) ? 32'h13579BDF : 32'h0);
            if (c == 1) begin
                checkWord("lat3 mem_addr", 32'(bus3.mem_addr), 32'h1A0);
            end
            @(posedge clk);
            #1;
        end
        bus3.b_req = 1'b0;
        bus3.mem_rdata = 32'h0;
        @(negedge clk);
        checkWord("lat3 b_rdata held", bus3.b_rdata, 32'h13579BDF);
        checkBit ("lat3 idle busy", bus3.busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
